// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the counter bank
package counter_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ch_state_t;

endpackage

// File: rtl/counter_ch.sv
// rtl/counter_ch.sv - single up/down counter channel with IDLE/RUN/DONE control
module counter_ch
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             clear,
  input  logic             set,
  input  logic [WIDTH-1:0] set_val,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  ch_state_t        state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic [WIDTH-1:0] term_q, term_nxt;
  logic             up_q, up_nxt;
  logic             tc_q, tc_nxt;
  logic [WIDTH-1:0] set_term;
  logic [WIDTH-1:0] step_val;

  // Terminal for a fresh load, and the next count value in the latched direction
  always_comb begin
    set_term = up ? limit : '0;
    step_val = up_q ? (count_q + ONE) : (count_q - ONE);
  end

  // State and datapath registers; reset aborts any count without a terminal pulse
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      term_q   <= '0;
      up_q     <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
      term_q   <= term_nxt;
      up_q     <= up_nxt;
      tc_q     <= tc_nxt;
    end
  end

  // Next state: clear beats set, set beats en; tc is high only on entry to DONE
  always_comb begin
    state_nxt  = state;
    count_nxt  = count_q;
    reload_nxt = reload_q;
    term_nxt   = term_q;
    up_nxt     = up_q;
    tc_nxt     = 1'b0;
    if (clear) begin
      state_nxt  = IDLE;
      count_nxt  = '0;
      reload_nxt = '0;
      term_nxt   = '0;
      up_nxt     = 1'b0;
    end else if (set) begin
      count_nxt  = set_val;
      reload_nxt = set_val;
      term_nxt   = set_term;
      up_nxt     = up;
      if (set_val != set_term) begin
        state_nxt = RUN;
      end else begin
        state_nxt = DONE;
        tc_nxt    = 1'b1;
      end
    end else if (en) begin
      case (state)
        RUN: begin
          count_nxt = step_val;
          if (step_val == term_q) begin
            state_nxt = DONE;
            tc_nxt    = 1'b1;
          end
        end
        DONE: begin
          if (AUTO_RELOAD != 0) begin
            count_nxt = reload_q;
            if (reload_q == term_q) begin
              tc_nxt = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches them combinationally
  always_comb begin
    count    = count_q;
    busy     = (state == RUN);
    done     = (state == DONE);
    tc_pulse = tc_q;
  end

endmodule

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of NUM_CH independent counter channels
module counter_bank
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int NUM_CH      = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       set,
  input  logic [NUM_CH*WIDTH-1:0] set_val,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH*WIDTH-1:0] limit,
  input  logic [NUM_CH-1:0]       en,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       tc_pulse
);

  // One channel per slice of the packed buses
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    counter_ch #(
      .WIDTH       (WIDTH),
      .AUTO_RELOAD (AUTO_RELOAD)
    ) u_ch (
      .clk      (clk),
      .rst_l    (rst_l),
      .clear    (clear),
      .set      (set[i]),
      .set_val  (set_val[i*WIDTH +: WIDTH]),
      .up       (up[i]),
      .limit    (limit[i*WIDTH +: WIDTH]),
      .en       (en[i]),
      .count    (count[i*WIDTH +: WIDTH]),
      .busy     (busy[i]),
      .done     (done[i]),
      .tc_pulse (tc_pulse[i])
    );
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - scoreboard bench for counter_bank, hold and auto-reload variants
module tb_counter_bank;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_l;
  logic         clear;
  logic [N-1:0] set, up, en;
  logic [N*W-1:0] set_val, limit;

  logic [N*W-1:0] count_h, count_r;
  logic [N-1:0]   busy_h, done_h, tc_h, busy_r, done_r, tc_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_bank #(.WIDTH(W), .NUM_CH(N), .AUTO_RELOAD(0)) dut_hold (
    .clk(clk), .rst_l(rst_l), .clear(clear), .set(set), .set_val(set_val),
    .up(up), .limit(limit), .en(en), .count(count_h), .busy(busy_h),
    .done(done_h), .tc_pulse(tc_h)
  );

  counter_bank #(.WIDTH(W), .NUM_CH(N), .AUTO_RELOAD(1)) dut_rel (
    .clk(clk), .rst_l(rst_l), .clear(clear), .set(set), .set_val(set_val),
    .up(up), .limit(limit), .en(en), .count(count_r), .busy(busy_r),
    .done(done_r), .tc_pulse(tc_r)
  );

  typedef struct packed {
    logic [N*W-1:0] cnt_h, cnt_r;
    logic [N-1:0]   busy_h, done_h, tc_h, busy_r, done_r, tc_r;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: index 0 = hold at terminal, 1 = auto-reload
  // Phase codes: 0 idle, 1 counting, 2 finished
  int m_cnt[2][N], m_rel[2][N], m_up[2][N], m_term[2][N], m_ph[2][N], m_tc[2][N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        m_cnt[d][c] = 0; m_rel[d][c] = 0; m_up[d][c] = 0;
        m_term[d][c] = 0; m_ph[d][c] = 0; m_tc[d][c] = 0;
      end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        m_tc[d][c] = 0;
        if (clear) begin
          m_cnt[d][c] = 0; m_rel[d][c] = 0; m_up[d][c] = 0;
          m_term[d][c] = 0; m_ph[d][c] = 0;
        end else if (set[c]) begin
          m_cnt[d][c]  = int'(set_val[c*W +: W]);
          m_rel[d][c]  = m_cnt[d][c];
          m_up[d][c]   = int'(up[c]);
          m_term[d][c] = up[c] ? int'(limit[c*W +: W]) : 0;
          if (m_cnt[d][c] == m_term[d][c]) begin
            m_ph[d][c] = 2; m_tc[d][c] = 1;
          end else begin
            m_ph[d][c] = 1;
          end
        end else if (en[c]) begin
          if (m_ph[d][c] == 1) begin
            m_cnt[d][c] = m_up[d][c] != 0 ? (m_cnt[d][c] + 1) % 256 : (m_cnt[d][c] + 255) % 256;
            if (m_cnt[d][c] == m_term[d][c]) begin
              m_ph[d][c] = 2; m_tc[d][c] = 1;
            end
          end else if (m_ph[d][c] == 2 && d == 1) begin
            m_cnt[d][c] = m_rel[d][c];
            if (m_cnt[d][c] == m_term[d][c]) m_tc[d][c] = 1;
            else m_ph[d][c] = 1;
          end
        end
      end
  endtask

  task automatic push_expect();
    exp_t e;
    e = '0;
    for (int c = 0; c < N; c++) begin
      e.cnt_h[c*W +: W] = W'(m_cnt[0][c]);
      e.cnt_r[c*W +: W] = W'(m_cnt[1][c]);
      e.busy_h[c] = (m_ph[0][c] == 1);
      e.done_h[c] = (m_ph[0][c] == 2);
      e.tc_h[c]   = (m_tc[0][c] != 0);
      e.busy_r[c] = (m_ph[1][c] == 1);
      e.done_r[c] = (m_ph[1][c] == 2);
      e.tc_r[c]   = (m_tc[1][c] != 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic c, input logic [N-1:0] s, input logic [N*W-1:0] sv,
                       input logic [N-1:0] u, input logic [N*W-1:0] lm, input logic [N-1:0] e);
    clear = c; set = s; set_val = sv; up = u; limit = lm; en = e;
    model_step();
    push_expect();
  endtask

  task automatic cycle(input logic c, input logic [N-1:0] s, input logic [N*W-1:0] sv,
                       input logic [N-1:0] u, input logic [N*W-1:0] lm, input logic [N-1:0] e);
    @(negedge clk);
    drive(c, s, sv, u, lm, e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_count_hold"}, count_h, 0);
    chk({tag, "_count_rel"}, count_r, 0);
    chk({tag, "_busy"}, {28'd0, busy_h | busy_r}, 0);
    chk({tag, "_done"}, {28'd0, done_h | done_r}, 0);
    chk({tag, "_tc"}, {28'd0, tc_h | tc_r}, 0);
  endtask

  // Asynchronous reset pulse between clock edges, then one idle-but-enabled cycle
  task automatic reset_pulse();
    @(negedge clk);
    #1 rst_l = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    #1 rst_l = 1'b1;
    drive(1'b0, '0, '0, '0, '0, {N{1'b1}});
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count_hold", count_h, e.cnt_h);
        chk("busy_hold", {28'd0, busy_h}, {28'd0, e.busy_h});
        chk("done_hold", {28'd0, done_h}, {28'd0, e.done_h});
        chk("tc_hold", {28'd0, tc_h}, {28'd0, e.tc_h});
        chk("count_rel", count_r, e.cnt_r);
        chk("busy_rel", {28'd0, busy_r}, {28'd0, e.busy_r});
        chk("done_rel", {28'd0, done_r}, {28'd0, e.done_r});
        chk("tc_rel", {28'd0, tc_r}, {28'd0, e.tc_r});
      end
    end
  end

  initial begin
    logic [N*W-1:0] sv, lm;
    rst_l = 1'b0; clear = 1'b0; set = '0; up = '0; en = '0;
    set_val = '0; limit = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_zero("reset_state");
    @(negedge clk);
    rst_l = 1'b1;

    // ch0 down from 3, en held, then five more cycles in DONE
    cycle(1'b0, 4'b0001, 32'h0000_0003, 4'b0000, 32'h0, 4'b1111);
    repeat (8) cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 32'h0, 4'b1111);

    // ch1 up from FE to limit 01 through the wrap
    cycle(1'b0, 4'b0010, 32'h0000_FE00, 4'b0010, 32'h0000_0100, 4'b0010);
    repeat (5) cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 32'h0, 4'b0010);

    // ch2 set with clear in the same cycle
    cycle(1'b0, 4'b0100, 32'h0005_0000, 4'b0000, 32'h0, 4'b0000);
    cycle(1'b1, 4'b0100, 32'h0009_0000, 4'b0000, 32'h0, 4'b0100);
    repeat (2) cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 32'h0, 4'b0100);

    // ch0 down from 2 with en high: reload variant repeats 2,1,0
    cycle(1'b0, 4'b0001, 32'h0000_0002, 4'b0000, 32'h0, 4'b0001);
    repeat (7) cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 32'h0, 4'b0001);

    // ch3 load of 0 counting down: immediate DONE
    cycle(1'b0, 4'b1000, 32'h0000_0000, 4'b0000, 32'h0, 4'b0000);
    repeat (3) cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 32'h0, 4'b0000);

    // reset mid-count, then en alone must not restart
    cycle(1'b0, 4'b0001, 32'h0000_000A, 4'b0000, 32'h0, 4'b0001);
    repeat (3) cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 32'h0, 4'b0001);
    reset_pulse();
    repeat (4) cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 32'h0, 4'b1111);

    // randomized traffic with small values so terminals are hit often
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        sv[c*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
        lm[c*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
      end
      cycle(($urandom_range(0, 39) == 0), N'($urandom & $urandom), sv,
            N'($urandom), lm, N'($urandom | $urandom));
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bits per counter channel.
REQ-002 SHALL have parameter NUM_CH, default 4, number of independent channels, legal range 1..16.
REQ-003 SHALL have parameter AUTO_RELOAD, default 0; 0 = hold at terminal, 1 = reload on next step after terminal.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_l, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1, synchronous active-high clear of all channels.
REQ-007 SHALL have port set, input, NUM_CH, per-channel load strobe.
REQ-008 SHALL have port set_val, input, NUM_CH*WIDTH, per-channel load value; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port up, input, NUM_CH, per-channel direction, sampled only when set is high: 1 = up, 0 = down.
REQ-010 SHALL have port limit, input, NUM_CH*WIDTH, per-channel up-count terminal value, sampled only when set is high.
REQ-011 SHALL have port en, input, NUM_CH, per-channel step enable.
REQ-012 SHALL have port count, output, NUM_CH*WIDTH, per-channel current count, same packing as set_val.
REQ-013 SHALL have port busy, output, NUM_CH, high while the channel is in RUN.
REQ-014 SHALL have port done, output, NUM_CH, high while the channel is in DONE.
REQ-015 SHALL have port tc_pulse, output, NUM_CH, one-cycle pulse on entry to DONE.

Function
REQ-016 Each channel SHALL run an FSM with states IDLE, RUN and DONE, fully independent of the other channels.
REQ-017 Per-channel priority SHALL be clear > set > en.
REQ-018 On clear, every channel SHALL go to IDLE with count = 0; reload value, direction and terminal registers = 0; tc_pulse = 0.
REQ-019 On set in any state, the channel SHALL latch set_val into count and the reload register, and SHALL latch up and limit.
REQ-020 The terminal value SHALL be 0 when the latched direction is down, and the latched limit when it is up.
REQ-021 On set, the channel SHALL enter RUN if set_val differs from the terminal; otherwise it SHALL enter DONE and pulse tc_pulse.
REQ-022 In RUN with en = 1, count SHALL step by 1 in the latched direction; en = 0 SHALL hold the count.
REQ-023 When a RUN step makes count equal the terminal, the channel SHALL enter DONE and assert tc_pulse for exactly the first cycle in which the new count is visible.
REQ-024 Up-counting with the terminal below the start value SHALL wrap modulo 2^WIDTH and continue until the terminal is reached.
REQ-025 In DONE with AUTO_RELOAD = 0, the channel SHALL ignore en, hold count, and never underflow or overflow.
REQ-026 In DONE with AUTO_RELOAD = 1, en SHALL reload count from the reload register and return to RUN, or re-enter DONE with a new tc_pulse if the reload value equals the terminal.
REQ-027 In IDLE, the channel SHALL ignore en and hold count.
REQ-028 busy, done and tc_pulse SHALL be registered outputs with no combinational path from any input.
REQ-029 Latency from a set or en edge to the updated count, busy, done and tc_pulse SHALL be exactly one cycle.

Reset
REQ-030 While rst_l = 0, every channel SHALL be in IDLE with count = 0, busy = 0, done = 0, tc_pulse = 0, independent of clk.
REQ-031 Reset asserted mid-count SHALL abort the count with no tc_pulse; after release the channel SHALL act only on a new set.

Structure
REQ-032 A shared package counter_pkg SHALL hold the channel-state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-033 One sub-module, counter_ch, SHALL implement a single channel; counter_bank SHALL instantiate NUM_CH copies through a generate loop.

Verification
REQ-034 The bench SHALL cover: WIDTH=8, ch0 set_val=3, up=0, en held high -> count 3,2,1,0; tc_pulse on the cycle count=0; done stays high and count stays 0 for 5 more cycles.
REQ-035 The bench SHALL cover: ch1 up=1, set_val=0xFE, limit=0x01 -> count FE,FF,00,01; tc_pulse once at 01.
REQ-036 The bench SHALL cover: set and clear in the same cycle on ch2 -> count=0, IDLE, no tc_pulse.
REQ-037 The bench SHALL cover: AUTO_RELOAD=1, set_val=2, down, en high -> count 2,1,0,2,1,0 with tc_pulse on each 0.
REQ-038 The bench SHALL cover: set_val=0 with down direction -> immediate DONE with a single tc_pulse.
REQ-039 The bench SHALL cover: rst_l pulsed low mid-count between clock edges -> outputs zero immediately; en then has no effect until a new set.
